// File: rtl/mmio_responder_pkg.sv
// Shared register map for the MMIO responder: offsets, bit positions, base.
// Imported by the responder, the CPU top and the bench.
package mmio_responder_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'hFFFF_0000;

  localparam logic [2:0] OFF_TXDATA = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_TIMER  = 3'd2;
  localparam logic [2:0] OFF_CTRL   = 3'd3;
  localparam logic [2:0] OFF_ACK    = 3'd4;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_CNT_LSB = 2;
  localparam int STAT_EXP     = 5;
  localparam int STAT_OVF     = 6;

  localparam int CTRL_TEN = 0;
  localparam int CTRL_IEN = 1;

  function automatic logic [31:0] status_word(
    input logic       full,
    input logic       empty,
    input logic [2:0] cnt,
    input logic       expired,
    input logic       ovf
  );
    logic [31:0] w;
    w = '0;
    w[STAT_FULL]  = full;
    w[STAT_EMPTY] = empty;
    w[STAT_CNT_LSB +: 3] = cnt;
    w[STAT_EXP]   = expired;
    w[STAT_OVF]   = ovf;
    return w;
  endfunction

endpackage

// File: rtl/mmio_responder_if.sv
// CPU-side MMIO bus plus TX byte stream of the responder.
// master = CPU/consumer side, slave = responder side.
interface mmio_responder_if;
  logic [31:0] address;
  logic        wr;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        sel;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  modport master (
    output address, wr, datain, tx_ready,
    input  dataout, sel, tx_data, tx_valid, irq
  );

  modport slave (
    input  address, wr, datain, tx_ready,
    output dataout, sel, tx_data, tx_valid, irq
  );
endinterface

// File: rtl/mmio_responder_tx_fifo.sv
// TX byte FIFO: power-of-two depth, pointers wrap naturally.
// Head is read combinationally from storage.
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               din_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [7:0]               head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rp_q];

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push_i) wp_d = wp_q + 1'b1;
    if (pop_i)  rp_d = rp_q + 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is not reset; an empty count makes stale bytes invisible.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= din_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped TX FIFO + interval timer in a 32-byte I/O window.
// One-cycle registered readback, matching data memory latency.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        wr,
  input  logic [31:0] datain,
  output logic [31:0] dataout,
  output logic        sel,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit;
  logic [2:0]    off;
  logic          wr_tx, wr_tmr, wr_ctl, wr_ack;
  logic          push, pop, full, empty;
  logic [CW-1:0] fifo_cnt;
  logic [31:0]   cnt32;
  logic [2:0]    cnt_sat;
  logic          expire;
  logic [31:0]   rdata;
  logic          unused_addr_bits;

  logic [1:0]  ctrl_q, ctrl_d;
  logic [31:0] tmr_q, tmr_d;
  logic [31:0] reload_q, reload_d;
  logic        exp_q, exp_d;
  logic        ovf_q, ovf_d;
  logic [31:0] dout_q, dout_d;
  logic        sel_q, sel_d;

  assign unused_addr_bits = ^address[1:0];

  assign hit = (address[31:5] == BASE_ADDR[31:5]);
  assign off = address[4:2];

  always_comb begin
    wr_tx  = 1'b0;
    wr_tmr = 1'b0;
    wr_ctl = 1'b0;
    wr_ack = 1'b0;
    if (wr && hit) begin
      unique case (1'b1)
        off == OFF_TXDATA: wr_tx  = 1'b1;
        off == OFF_TIMER:  wr_tmr = 1'b1;
        off == OFF_CTRL:   wr_ctl = 1'b1;
        off == OFF_ACK:    wr_ack = 1'b1;
        default: ;
      endcase
    end
  end

  // A pop in the same cycle frees the slot a write to a full FIFO needs.
  assign pop  = tx_valid && tx_ready;
  assign push = wr_tx && (!full || pop);

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (datain[7:0]),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_cnt),
    .head_o  (tx_data)
  );

  assign tx_valid = !empty;
  assign cnt32    = 32'(fifo_cnt);
  assign cnt_sat  = (cnt32 > 32'd7) ? 3'd7 : cnt32[2:0];

  always_comb begin
    tmr_d    = tmr_q;
    reload_d = reload_q;
    expire   = 1'b0;
    if (wr_tmr) begin
      tmr_d    = datain;
      reload_d = datain;
    end else if (ctrl_q[CTRL_TEN]) begin
      if (tmr_q == '0) begin
        expire = 1'b1;
        tmr_d  = reload_q;
      end else begin
        tmr_d = tmr_q - 32'd1;
      end
    end
  end

  always_comb begin
    ctrl_d = wr_ctl ? datain[1:0] : ctrl_q;
    exp_d  = expire ? 1'b1 : (wr_ack ? 1'b0 : exp_q);
    ovf_d  = (wr_tx && full && !pop) ? 1'b1 :
             (wr_ack ? 1'b0 : ovf_q);
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      off == OFF_STATUS:
        rdata = status_word(full, empty, cnt_sat, exp_q, ovf_q);
      off == OFF_TIMER: rdata = tmr_q;
      off == OFF_CTRL:  rdata = {30'd0, ctrl_q};
      default: rdata = '0;
    endcase
    sel_d  = hit;
    dout_d = hit ? rdata : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q   <= '0;
      tmr_q    <= '0;
      reload_q <= '0;
      exp_q    <= 1'b0;
      ovf_q    <= 1'b0;
      dout_q   <= '0;
      sel_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      tmr_q    <= tmr_d;
      reload_q <= reload_d;
      exp_q    <= exp_d;
      ovf_q    <= ovf_d;
      dout_q   <= dout_d;
      sel_q    <= sel_d;
    end
  end

  assign dataout = dout_q;
  assign sel     = sel_q;
  assign irq     = exp_q && ctrl_q[CTRL_IEN];

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: register table plus
// hand sequences for FIFO, overflow, timer and reset corners.
module tb_mmio_responder;
  import mmio_responder_pkg::*;

  localparam logic [31:0] B = BASE_ADDR_DEF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mmio_responder_if bus ();

  mmio_responder #(.BASE_ADDR(B), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (bus.address),
    .wr       (bus.wr),
    .datain   (bus.datain),
    .dataout  (bus.dataout),
    .sel      (bus.sel),
    .tx_data  (bus.tx_data),
    .tx_valid (bus.tx_valid),
    .tx_ready (bus.tx_ready),
    .irq      (bus.irq)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic        exp_sel;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs [21];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    bus.wr      = 1'b1;
    bus.datain  = d;
    @(posedge clk);
    #1;
    bus.wr      = 1'b0;
    bus.address = 32'h0;
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d,
                        output logic s);
    @(negedge clk);
    bus.address = a;
    bus.wr      = 1'b0;
    @(posedge clk);
    #1;
    d = bus.dataout;
    s = bus.sel;
    bus.address = 32'h0;
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic c,
                              input logic s, input logic [31:0] e);
    vec_t v;
    v.wr = w; v.addr = a; v.wdata = d;
    v.chk = c; v.exp_sel = s; v.exp_dout = e;
    return v;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] d;
    logic        s;
    logic [7:0]  drain_exp [4];
    bit          seen;

    drain_exp[0] = 8'h02; drain_exp[1] = 8'h03;
    drain_exp[2] = 8'h04; drain_exp[3] = 8'h06;

    vecs[0]  = mk(0, B + 32'h04, 0, 1, 1, 32'h2);
    vecs[1]  = mk(0, B + 32'h0C, 0, 1, 1, 32'h0);
    vecs[2]  = mk(0, B + 32'h08, 0, 1, 1, 32'h0);
    vecs[3]  = mk(1, B + 32'h0C, 32'hFFFF_FFFE, 0, 0, 0);
    vecs[4]  = mk(0, B + 32'h0C, 0, 1, 1, 32'h2);
    vecs[5]  = mk(1, B + 32'h0C, 32'h0, 0, 0, 0);
    vecs[6]  = mk(0, B + 32'h0C, 0, 1, 1, 32'h0);
    vecs[7]  = mk(1, B + 32'h08, 32'h5, 0, 0, 0);
    vecs[8]  = mk(0, B + 32'h0B, 0, 1, 1, 32'h5);
    vecs[9]  = mk(0, B + 32'h14, 0, 1, 1, 32'h0);
    vecs[10] = mk(1, B + 32'h18, 32'hFFFF_FFFF, 0, 0, 0);
    vecs[11] = mk(0, B + 32'h18, 0, 1, 1, 32'h0);
    vecs[12] = mk(0, B + 32'h1C, 0, 1, 1, 32'h0);
    vecs[13] = mk(0, B + 32'h20, 0, 1, 0, 32'h0);
    vecs[14] = mk(1, B + 32'h20, 32'h55, 0, 0, 0);
    vecs[15] = mk(1, B + 32'h2C, 32'h3, 0, 0, 0);
    vecs[16] = mk(0, B + 32'h04, 0, 1, 1, 32'h2);
    vecs[17] = mk(0, B + 32'h0C, 0, 1, 1, 32'h0);
    vecs[18] = mk(0, B - 32'h04, 0, 1, 0, 32'h0);
    vecs[19] = mk(0, B + 32'h00, 0, 1, 1, 32'h0);
    vecs[20] = mk(1, B + 32'h10, 32'h0, 0, 0, 0);

    bus.address  = 32'h0;
    bus.wr       = 1'b0;
    bus.datain   = 32'h0;
    bus.tx_ready = 1'b0;

    // Reset state
    #12;
    check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_irq", {31'd0, bus.irq}, 32'd0);
    check("rst_sel", {31'd0, bus.sel}, 32'd0);
    check("rst_dout", bus.dataout, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Register table
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      bus.address = vecs[i].addr;
      bus.wr      = vecs[i].wr;
      bus.datain  = vecs[i].wdata;
      @(posedge clk);
      #1;
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_sel", i), {31'd0, bus.sel},
              {31'd0, vecs[i].exp_sel});
        check($sformatf("vec%0d_dout", i), bus.dataout,
              vecs[i].exp_dout);
      end
    end
    bus.wr = 1'b0;
    bus.address = 32'h0;
    check("tbl_no_push", {31'd0, bus.tx_valid}, 32'd0);

    // Two bytes queued, then drained over two ready cycles
    wr_reg(B + 32'h00, 32'h141);
    check("txv_rise", {31'd0, bus.tx_valid}, 32'd1);
    check("head_41", {24'd0, bus.tx_data}, 32'h41);
    wr_reg(B + 32'h00, 32'h42);
    rd_reg(B + 32'h04, d, s);
    check("status_2q", d, 32'h8);
    @(negedge clk);
    bus.tx_ready = 1'b1;
    check("drain_41", {24'd0, bus.tx_data}, 32'h41);
    @(negedge clk);
    check("drain_42", {24'd0, bus.tx_data}, 32'h42);
    check("drain_v", {31'd0, bus.tx_valid}, 32'd1);
    @(negedge clk);
    bus.tx_ready = 1'b0;
    check("drained_empty", {31'd0, bus.tx_valid}, 32'd0);
    rd_reg(B + 32'h04, d, s);
    check("status_empty", d, 32'h2);

    // Overflow on fifth write
    for (int i = 1; i <= 5; i++) wr_reg(B, 32'(i));
    rd_reg(B + 32'h04, d, s);
    check("status_ovf", d, 32'h51);
    check("ovf_head", {24'd0, bus.tx_data}, 32'h01);
    wr_reg(B + 32'h10, 32'h0);
    rd_reg(B + 32'h04, d, s);
    check("status_ack", d, 32'h11);

    // Full FIFO: write with a same-cycle pop is accepted
    @(negedge clk);
    bus.address  = B;
    bus.wr       = 1'b1;
    bus.datain   = 32'h06;
    bus.tx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
    bus.address = 32'h0;
    bus.tx_ready = 1'b0;
    check("pp_head", {24'd0, bus.tx_data}, 32'h02);
    rd_reg(B + 32'h04, d, s);
    check("pp_status", d, 32'h11);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.tx_ready = 1'b1;
      check($sformatf("pp_drain%0d", i), {24'd0, bus.tx_data},
            {24'd0, drain_exp[i]});
    end
    @(negedge clk);
    bus.tx_ready = 1'b0;
    check("pp_empty", {31'd0, bus.tx_valid}, 32'd0);

    // Timer: reload 3 gives a 4-cycle period
    wr_reg(B + 32'h08, 32'd3);
    wr_reg(B + 32'h0C, 32'd3);
    check("tmr_irq_0", {31'd0, bus.irq}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("tmr_irq_c%0d", k), {31'd0, bus.irq},
            {31'd0, k == 4});
    end
    wr_reg(B + 32'h10, 32'h0);
    check("tmr_ack", {31'd0, bus.irq}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("tmr_rec_c%0d", k), {31'd0, bus.irq},
            {31'd0, k == 3});
    end
    rd_reg(B + 32'h04, d, s);
    check("status_exp", d, 32'h22);
    wr_reg(B + 32'h10, 32'h0);

    // Reset mid-operation
    wr_reg(B, 32'h0A);
    wr_reg(B, 32'h0B);
    wr_reg(B, 32'h0C);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (bus.irq) seen = 1'b1;
    end
    check("pre_rst_irq", {31'd0, seen}, 32'd1);
    check("pre_rst_txv", {31'd0, bus.tx_valid}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_txv", {31'd0, bus.tx_valid}, 32'd0);
    check("mid_rst_irq", {31'd0, bus.irq}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd_reg(B + 32'h04, d, s);
    check("post_rst_status", d, 32'h2);
    rd_reg(B + 32'h0C, d, s);
    check("post_rst_ctrl", d, 32'h0);
    rd_reg(B + 32'h08, d, s);
    check("post_rst_timer", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
MMIO_RESPONDER -- requirements
Module: mmio_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hFFFF_0000, base of the 32-byte I/O window.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, TX FIFO entries (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port address  input  32  byte address from the CPU memory-address mux.
REQ-006 SHALL have port wr  input  1  1 = write, 0 = read (same sense as the CPU memory write signal).
REQ-007 SHALL have port datain  input  32  CPU store data.
REQ-008 SHALL have port dataout  output  32  registered read data.
REQ-009 SHALL have port sel  output  1  registered window hit; the top selects dataout over memory when 1.
REQ-010 SHALL have port tx_data  output  8  FIFO head byte.
REQ-011 SHALL have port tx_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port tx_ready  input  1  consumer accepts the head byte.
REQ-013 SHALL have port irq  output  1  timer interrupt request.

Function
REQ-014 SHALL decode a hit when address[31:5] == BASE_ADDR[31:5]; offset = address[4:2]; address[1:0] ignored.
REQ-015 SHALL map offsets as: 0 TXDATA (W), 1 STATUS (R), 2 TIMER (W: load value; R: current count), 3 CTRL (R/W), 4 ACK (W); offsets 5-7 read 0 and ignore writes.
REQ-016 SHALL register dataout and sel one cycle after address is presented (one-cycle read latency, matching memory); on a miss dataout = 0 and sel = 0.
REQ-017 SHALL perform writes on the rising edge where wr=1 and a hit is decoded; wr=1 with a miss has no effect.
REQ-018 SHALL format STATUS as bit0 full, bit1 empty, bits[4:2] count (saturating at 7), bit5 expired, bit6 overflow, other bits 0.
REQ-019 SHALL format CTRL as bit0 timer_en, bit1 irq_en; other bits written are ignored and read 0.
REQ-020 SHALL push datain[7:0] on a TXDATA write when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-021 SHALL drop a TXDATA write to a full FIFO with no same-cycle pop, and set sticky overflow.
REQ-022 SHALL pop when tx_valid && tx_ready; tx_data is the head entry, combinational from storage; simultaneous push and pop leaves count unchanged.
REQ-023 SHALL wrap read and write pointers modulo FIFO_DEPTH; tx_valid SHALL rise the cycle after the first push into an empty FIFO.
REQ-024 SHALL load both the reload register and the counter from datain on a TIMER write, overriding any decrement that cycle.
REQ-025 SHALL, while timer_en = 1, decrement the counter each cycle; when counter == 0 it SHALL set expired and reload from the reload register in that cycle (reload 0 -> expires every cycle).
REQ-026 SHALL clear expired and overflow on any ACK write; a same-cycle expiry SHALL win, leaving expired = 1.
REQ-027 SHALL drive irq = expired && irq_en combinationally from registers.

Reset
REQ-028 SHALL, while reset = 0, asynchronously clear FIFO pointers and count, counter, reload, CTRL, expired, overflow, dataout and sel; tx_valid = 0 and irq = 0 follow.
REQ-029 SHALL discard FIFO contents and any in-progress timer count on reset mid-operation; no partial push or pop survives.

Structure
REQ-030 SHALL place register offsets, STATUS/CTRL bit positions and the BASE_ADDR default in a shared package used by the CPU top and the bench.
REQ-031 SHALL implement the FIFO as sub-module tx_fifo (push, pop, full, empty, count, head); decode, timer and readback stay in mmio_responder.

Verification
REQ-032 SHALL cover: write 0x41, 0x42 to TXDATA with tx_ready = 0 -> tx_valid = 1, tx_data = 0x41, STATUS read = 0x0000_0008; raise tx_ready for 2 cycles -> 0x41 then 0x42 consumed, empty.
REQ-033 SHALL cover: 5 TXDATA writes with tx_ready = 0 (depth 4) -> 5th dropped, STATUS = 0x0000_0051; ACK write -> overflow cleared.
REQ-034 SHALL cover: full FIFO with tx_ready = 1 and TXDATA write in the same cycle -> write accepted, count stays 4.
REQ-035 SHALL cover: TIMER = 3, CTRL = 3 -> irq rises exactly 4 cycles after timer_en takes effect; ACK clears irq; expiry recurs every 4 cycles.
REQ-036 SHALL cover: read at BASE_ADDR+0x20 -> sel = 0, dataout = 0; write there -> no state change.
REQ-037 SHALL cover: assert reset with 3 entries queued and timer running -> tx_valid = 0, irq = 0, STATUS read after release = 0x0000_0002.
